// File: rtl/stage_sequencer.sv
// Four-stage instruction sequencer (FETCH/DECODE/EXECUTE/WRITEBACK) owning IR, PC and the memory request.
// Define STAGE_SEQUENCER_TIMEOUT_EN to enable the MEM_ACK stall timeout and MEM_ERR reporting.
module stage_sequencer #(
    parameter logic [15:0] RESET_PC       = 16'h3000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        IR_LE,
    input  logic        PC_LE,
    input  logic        PC_CONTROL,
    input  logic [15:0] ALU_Y,
    input  logic [15:0] MAR,
    input  logic [15:0] MEM_RDATA,
    input  logic        MEM_ACK,
    output logic [1:0]  STAGE,
    output logic [15:0] IR,
    output logic [15:0] PC,
    output logic        MEM_REQ,
    output logic [15:0] MEM_ADDR,
    output logic        HALTED,
    output logic        MEM_ERR
);

    typedef enum logic [1:0] {
        DECODE    = 2'b00,
        EXECUTE   = 2'b01,
        WRITEBACK = 2'b10,
        FETCH     = 2'b11
    } stage_t;

    if (TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("stage_sequencer: TIMEOUT_CYCLES must be at least 1");
    end

    stage_t stage, next_stage;
    logic   halted;
    logic   wb_mem;
    logic   ir_load;
    logic   pc_load;
    logic   halt_now;
    logic   timeout_hit;

    always_comb begin
        next_stage = stage;
        MEM_REQ    = 1'b0;
        MEM_ADDR   = PC;
        ir_load    = 1'b0;
        pc_load    = 1'b0;
        halt_now   = 1'b0;
        wb_mem     = (IR[15:12] == 4'b0110) || (IR[15:12] == 4'b0111);
        if (!halted) begin
            unique case (stage)
                FETCH: begin
                    MEM_REQ = 1'b1;
                    if (MEM_ACK) begin
                        ir_load    = IR_LE;
                        next_stage = DECODE;
                    end
                end
                DECODE: next_stage = EXECUTE;
                EXECUTE: begin
                    pc_load    = PC_LE;
                    next_stage = WRITEBACK;
                end
                WRITEBACK: begin
                    // Only LDR/STR touch memory here; everything else retires in one cycle.
                    if (wb_mem) begin
                        MEM_REQ  = 1'b1;
                        MEM_ADDR = MAR;
                    end
                    if (!wb_mem || MEM_ACK) begin
                        next_stage = FETCH;
                        halt_now   = (IR == 16'hF025);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stage  <= FETCH;
            IR     <= '0;
            PC     <= RESET_PC;
            halted <= 1'b0;
        end else if (timeout_hit) begin
            stage  <= FETCH;
            halted <= 1'b1;
        end else begin
            stage <= next_stage;
            if (ir_load) IR <= MEM_RDATA;
            if (pc_load) PC <= PC_CONTROL ? ALU_Y : PC + 16'd1;
            if (halt_now) halted <= 1'b1;
        end
    end

`ifdef STAGE_SEQUENCER_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wait_cnt;
    logic          mem_err;

    // Fires on the stalled edge that would make the count reach TIMEOUT_CYCLES.
    assign timeout_hit = MEM_REQ && !MEM_ACK && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else if (timeout_hit) begin
            wait_cnt <= '0;
            mem_err  <= 1'b1;
        end else if (MEM_REQ && !MEM_ACK) begin
            wait_cnt <= wait_cnt + CW'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    assign MEM_ERR = mem_err;
`else
    assign timeout_hit = 1'b0;
    assign MEM_ERR     = 1'b0;
`endif

    assign STAGE  = stage;
    assign HALTED = halted;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed self-checking bench for stage_sequencer: sequencing, stalls, PC update, halt, reset and timeout.
module tb_stage_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IR_LE;
    logic        PC_LE;
    logic        PC_CONTROL;
    logic [15:0] ALU_Y;
    logic [15:0] MAR;
    logic [15:0] MEM_RDATA;
    logic        MEM_ACK;
    logic [1:0]  STAGE;
    logic [15:0] IR;
    logic [15:0] PC;
    logic        MEM_REQ;
    logic [15:0] MEM_ADDR;
    logic        HALTED;
    logic        MEM_ERR;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    stage_sequencer #(
        .RESET_PC       (16'h3000),
        .TIMEOUT_CYCLES (255)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .IR_LE      (IR_LE),
        .PC_LE      (PC_LE),
        .PC_CONTROL (PC_CONTROL),
        .ALU_Y      (ALU_Y),
        .MAR        (MAR),
        .MEM_RDATA  (MEM_RDATA),
        .MEM_ACK    (MEM_ACK),
        .STAGE      (STAGE),
        .IR         (IR),
        .PC         (PC),
        .MEM_REQ    (MEM_REQ),
        .MEM_ADDR   (MEM_ADDR),
        .HALTED     (HALTED),
        .MEM_ERR    (MEM_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge CLK);
    endtask

    // One non-memory instruction from FETCH back to FETCH with immediate ACK.
    task automatic run_instr(input logic [15:0] rdata, input logic le, input logic ctl,
                             input logic [15:0] alu);
        IR_LE      = 1'b1;
        MEM_ACK    = 1'b1;
        MEM_RDATA  = rdata;
        PC_LE      = le;
        PC_CONTROL = ctl;
        ALU_Y      = alu;
        repeat (4) step();
    endtask

    initial begin
        RST = 1'b1; IR_LE = 1'b0; PC_LE = 1'b0; PC_CONTROL = 1'b0;
        ALU_Y = '0; MAR = '0; MEM_RDATA = '0; MEM_ACK = 1'b1;
        repeat (2) step();
        check_val("rst_stage", STAGE, 16'd3);
        check_val("rst_ir", IR, 16'h0000);
        check_val("rst_pc", PC, 16'h3000);
        check_val("rst_halted", HALTED, 16'd0);
        check_val("rst_err", MEM_ERR, 16'd0);
        check_val("rst_req", MEM_REQ, 16'd1);

        // ADD with ACK every cycle
        RST = 1'b0; MEM_ACK = 1'b1; MEM_RDATA = 16'h1021; IR_LE = 1'b1; PC_LE = 1'b1; PC_CONTROL = 1'b0;
        check_val("add_fetch_stage", STAGE, 16'd3);
        check_val("add_fetch_addr", MEM_ADDR, 16'h3000);
        step();
        check_val("add_dec_stage", STAGE, 16'd0);
        check_val("add_dec_ir", IR, 16'h1021);
        check_val("add_dec_req", MEM_REQ, 16'd0);
        step();
        check_val("add_exe_stage", STAGE, 16'd1);
        check_val("add_exe_pc", PC, 16'h3000);
        step();
        check_val("add_wb_stage", STAGE, 16'd2);
        check_val("add_wb_pc", PC, 16'h3001);
        check_val("add_wb_req", MEM_REQ, 16'd0);
        step();
        check_val("add_next_stage", STAGE, 16'd3);
        check_val("add_next_addr", MEM_ADDR, 16'h3001);

        // fetch stall of 5 cycles, then LDR
        RST = 1'b1;
        step();
        RST = 1'b0; MEM_ACK = 1'b0; MEM_RDATA = 16'h6042; MAR = 16'h4000;
        for (int i = 0; i < 5; i++) begin
            check_val("stall_stage", STAGE, 16'd3);
            check_val("stall_req", MEM_REQ, 16'd1);
            check_val("stall_addr", MEM_ADDR, 16'h3000);
            step();
        end
        check_val("stall_still_fetch", STAGE, 16'd3);
        MEM_ACK = 1'b1;
        step();
        check_val("ldr_dec_stage", STAGE, 16'd0);
        check_val("ldr_ir", IR, 16'h6042);
        MEM_ACK = 1'b0;
        step();
        check_val("ldr_exe_stage", STAGE, 16'd1);
        step();
        check_val("ldr_wb_pc", PC, 16'h3001);
        for (int i = 0; i < 3; i++) begin
            check_val("ldr_wb_stage", STAGE, 16'd2);
            check_val("ldr_wb_req", MEM_REQ, 16'd1);
            check_val("ldr_wb_addr", MEM_ADDR, 16'h4000);
            step();
        end
        MEM_ACK = 1'b1;
        check_val("ldr_wb_stage4", STAGE, 16'd2);
        step();
        check_val("ldr_done_stage", STAGE, 16'd3);
        check_val("ldr_done_addr", MEM_ADDR, 16'h3001);

        // PC update boundaries
        run_instr(16'h1021, 1'b1, 1'b1, 16'hFFFF);
        check_val("pc_jump_ffff", PC, 16'hFFFF);
        run_instr(16'h1021, 1'b1, 1'b0, 16'h1234);
        check_val("pc_wrap", PC, 16'h0000);
        run_instr(16'h1021, 1'b1, 1'b1, 16'h3050);
        check_val("pc_jump", PC, 16'h3050);
        run_instr(16'h1021, 1'b0, 1'b1, 16'h1111);
        check_val("pc_hold_le0", PC, 16'h3050);

        // TRAP HALT
        run_instr(16'hF025, 1'b0, 1'b0, 16'h0000);
        check_val("halt_flag", HALTED, 16'd1);
        check_val("halt_stage", STAGE, 16'd3);
        check_val("halt_req", MEM_REQ, 16'd0);
        check_val("halt_ir", IR, 16'hF025);
        MEM_ACK = 1'b1; MEM_RDATA = 16'h1234; PC_LE = 1'b1; PC_CONTROL = 1'b1; ALU_Y = 16'h5555;
        repeat (3) step();
        check_val("frozen_stage", STAGE, 16'd3);
        check_val("frozen_pc", PC, 16'h3050);
        check_val("frozen_ir", IR, 16'hF025);
        check_val("frozen_req", MEM_REQ, 16'd0);
        check_val("frozen_halted", HALTED, 16'd1);
        RST = 1'b1;
        step();
        RST = 1'b0;
        check_val("unhalt_halted", HALTED, 16'd0);
        check_val("unhalt_pc", PC, 16'h3000);

        // reset in the middle of a fetch stall, with ACK arriving the same edge
        MEM_ACK = 1'b0;
        repeat (2) step();
        check_val("midstall_stage", STAGE, 16'd3);
        RST = 1'b1; MEM_ACK = 1'b1; MEM_RDATA = 16'h9999;
        step();
        RST = 1'b0; MEM_ACK = 1'b0;
        check_val("midrst_stage", STAGE, 16'd3);
        check_val("midrst_ir", IR, 16'h0000);
        check_val("midrst_pc", PC, 16'h3000);
        check_val("midrst_halted", HALTED, 16'd0);

`ifdef STAGE_SEQUENCER_TIMEOUT_EN
        repeat (254) step();
        check_val("to_err_early", MEM_ERR, 16'd0);
        check_val("to_halted_early", HALTED, 16'd0);
        step();
        check_val("to_err", MEM_ERR, 16'd1);
        check_val("to_halted", HALTED, 16'd1);
        check_val("to_stage", STAGE, 16'd3);
        check_val("to_req", MEM_REQ, 16'd0);
        RST = 1'b1;
        step();
        RST = 1'b0;
        check_val("to_rst_err", MEM_ERR, 16'd0);
        check_val("to_rst_halted", HALTED, 16'd0);
`else
        repeat (1000) step();
        check_val("nto_err", MEM_ERR, 16'd0);
        check_val("nto_halted", HALTED, 16'd0);
        check_val("nto_stage", STAGE, 16'd3);
        check_val("nto_req", MEM_REQ, 16'd1);
        MEM_ACK = 1'b1;
        step();
        check_val("nto_dec", STAGE, 16'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
